// File: rtl/fb_avl_port.sv
// fb_avl_port: frame buffer port onto an Avalon-MM master.
//
// A single frame of FRAME_WORDS pixels is written sequentially starting at
// BASE_ADDR and then read back in the same order. One command register holds
// the Avalon command in flight. It is reloaded whenever the slot is free or the
// slave takes the current command.
//
// Optional feature: define FB_OVERRUN_FLAG_EN to add the sticky `overrun`
// output. It flags requests made against a full frame or an exhausted read
// pointer.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   wr_en, wr_data      active-low write request and pixel
//   rd_en               active-low read request
//   avl_ready           command slot free this cycle (combinational)
//   full                frame completely written (level)
//   rd_done             one-cycle pulse once the frame is fully read back
//   avl_read_req        read accepted this cycle (combinational)
//   rd_data(_valid)     returned pixel, one cycle after avl_readdatavalid
//   avl_*               Avalon-MM master signals
//   overrun             (FB_OVERRUN_FLAG_EN only) sticky request-overrun flag
module fb_avl_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 25,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 307200,
  parameter int MAX_RD_PEND = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  avl_ready,
  output logic                  full,
  output logic                  rd_done,
  output logic                  avl_read_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [ADDR_WIDTH-1:0] avl_address,
  output logic                  avl_write,
  output logic [DATA_WIDTH-1:0] avl_writedata,
  output logic                  avl_read,
  input  logic                  avl_waitrequest,
  input  logic [DATA_WIDTH-1:0] avl_readdata,
  input  logic                  avl_readdatavalid
`ifdef FB_OVERRUN_FLAG_EN
  ,
  output logic                  overrun
`endif
);

  localparam int PTR_W  = $clog2(FRAME_WORDS + 1);
  localparam int PEND_W = $clog2(MAX_RD_PEND + 1);

  localparam logic [PTR_W-1:0]      PTR_END  = PTR_W'(FRAME_WORDS);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(FRAME_WORDS - 1);
  localparam logic [PEND_W-1:0]     PEND_MAX = PEND_W'(MAX_RD_PEND);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PEND_W-1:0] rd_pend;
  logic              cmd_valid;
  logic              wr_acc;
  logic              rd_acc;
  logic              rdv_ok;

  // The command register is encoded directly in avl_write/avl_read.
  assign cmd_valid = avl_write | avl_read;
  assign avl_ready = ~cmd_valid | ~avl_waitrequest;

  // full is only low in S_FILL, so it alone gates writes. A simultaneous read
  // request is dropped whenever a write is requested.
  assign wr_acc = ~wr_en & avl_ready & ~full;
  assign rd_acc = ~rd_en & wr_en & avl_ready &
                  (rd_ptr != PTR_END) & (rd_pend != PEND_MAX);
  assign avl_read_req = rd_acc;

  // Read data with nothing outstanding (e.g. left over from before a reset)
  // is discarded so rd_pend cannot underflow.
  assign rdv_ok = avl_readdatavalid & (rd_pend != '0);

  // Command register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avl_write     <= 1'b0;
      avl_read      <= 1'b0;
      avl_address   <= '0;
      avl_writedata <= '0;
    end else if (wr_acc) begin
      avl_write     <= 1'b1;
      avl_read      <= 1'b0;
      avl_address   <= BASE + ADDR_WIDTH'(wr_ptr);
      avl_writedata <= wr_data;
    end else if (rd_acc) begin
      avl_write     <= 1'b0;
      avl_read      <= 1'b1;
      avl_address   <= BASE + ADDR_WIDTH'(rd_ptr);
    end else if (avl_ready) begin
      // Slot was empty or the slave just took the command.
      avl_write <= 1'b0;
      avl_read  <= 1'b0;
    end
  end

  // Frame sequencing: pointers, full and rd_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full    <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        S_FILL: begin
          // full rises on the same edge that wr_ptr reaches FRAME_WORDS.
          if (wr_acc && (wr_ptr == PTR_LAST)) begin
            state <= S_DRAIN;
            full  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if ((rd_ptr == PTR_END) && (rd_pend == '0) && !cmd_valid) begin
            state   <= S_DONE;
            rd_done <= 1'b1;
          end
        end
        S_DONE: begin
          // Rewind for the next frame.
          state   <= S_FILL;
          rd_done <= 1'b0;
          full    <= 1'b0;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
        end
        default: begin
          state   <= S_FILL;
          rd_done <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding read counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= '0;
    end else begin
      case ({rd_acc, rdv_ok})
        2'b10:   rd_pend <= rd_pend + 1'b1;
        2'b01:   rd_pend <= rd_pend - 1'b1;
        default: rd_pend <= rd_pend;
      endcase
    end
  end

  // Read return stage (latency 1)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= rdv_ok;
      if (rdv_ok) rd_data <= avl_readdata;
    end
  end

`ifdef FB_OVERRUN_FLAG_EN
  // Sticky until reset: a request was made that can never be served this frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if ((~wr_en & full) | (~rd_en & (rd_ptr == PTR_END))) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_avl_port.sv
module tb_fb_avl_port;

  localparam int DW = 32;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          avl_ready;
  logic          full;
  logic          rd_done;
  logic          avl_read_req;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [AW-1:0] avl_address;
  logic          avl_write;
  logic [DW-1:0] avl_writedata;
  logic          avl_read;
  logic          avl_waitrequest;
  logic [DW-1:0] avl_readdata;
  logic          avl_readdatavalid;
`ifdef FB_OVERRUN_FLAG_EN
  logic          overrun;
`endif

  // Slave model state
  logic          slave_en;
  logic          stray_rv;
  logic          auto_rv;
  logic [DW-1:0] auto_rd;
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] rq_data [$];
  int            rq_due [$];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            cyc;

  int n_chk = 0;
  int n_err = 0;

  assign avl_readdatavalid = auto_rv | stray_rv;
  assign avl_readdata      = stray_rv ? 32'h0000_DEAD : auto_rd;

  fb_avl_port #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (32'h100),
    .FRAME_WORDS(4),
    .MAX_RD_PEND(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .rd_en            (rd_en),
    .avl_ready        (avl_ready),
    .full             (full),
    .rd_done          (rd_done),
    .avl_read_req     (avl_read_req),
    .rd_data          (rd_data),
    .rd_data_valid    (rd_data_valid),
    .avl_address      (avl_address),
    .avl_write        (avl_write),
    .avl_writedata    (avl_writedata),
    .avl_read         (avl_read),
    .avl_waitrequest  (avl_waitrequest),
    .avl_readdata     (avl_readdata),
    .avl_readdatavalid(avl_readdatavalid)
`ifdef FB_OVERRUN_FLAG_EN
    ,
    .overrun          (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Avalon slave: logs writes, answers reads 5 cycles after the handshake.
  initial begin
    auto_rv = 1'b0;
    auto_rd = '0;
    cyc     = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        rq_data.delete();
        rq_due.delete();
      end else begin
        if (avl_write && !avl_waitrequest) begin
          log_addr.push_back(avl_address);
          log_data.push_back(avl_writedata);
          mem[avl_address[3:0]] = avl_writedata;
        end
        if (avl_read && !avl_waitrequest) begin
          rq_data.push_back(mem[avl_address[3:0]]);
          rq_due.push_back(cyc + 5);
        end
      end
      @(negedge clk);
      if (slave_en && rq_due.size() > 0 && rq_due[0] <= cyc) begin
        auto_rv = 1'b1;
        auto_rd = rq_data.pop_front();
        void'(rq_due.pop_front());
      end else begin
        auto_rv = 1'b0;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_aw"},   avl_write, 0);
    chk({tag, "_ar"},   avl_read, 0);
    chk({tag, "_addr"}, avl_address, 0);
    chk({tag, "_wd"},   avl_writedata, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_done"}, rd_done, 0);
    chk({tag, "_rdv"},  rd_data_valid, 0);
    chk({tag, "_rd"},   rd_data, 0);
    chk({tag, "_rdy"},  avl_ready, 1);
`ifdef FB_OVERRUN_FLAG_EN
    chk({tag, "_ovr"},  overrun, 0);
`endif
  endtask

  initial begin
    int n_acc, n_rdv, n_data, n_done, n;
    logic prev_rdv, done_seen, finished;

    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = '0;
    avl_waitrequest = 1'b0; slave_en = 1'b0; stray_rv = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    nxt(); nxt();
    chk_reset_vals("rst");
    chk("rst_req", avl_read_req, 0);
    reset = 1'b0;

    // Four writes, write A1 stalled by waitrequest for 3 cycles
    nxt(); wr_en = 1'b0; wr_data = 32'hA0;
    #1 chk("w0_rdy", avl_ready, 1);
    nxt();
    chk("w0_aw", avl_write, 1); chk("w0_addr", avl_address, 32'h100); chk("w0_wd", avl_writedata, 32'hA0);
    wr_data = 32'hA1;
    nxt();
    chk("w1_addr", avl_address, 32'h101); chk("w1_wd", avl_writedata, 32'hA1);
    avl_waitrequest = 1'b1; wr_data = 32'hA2;
    #1 chk("wait_rdy", avl_ready, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("hold_aw", avl_write, 1); chk("hold_addr", avl_address, 32'h101); chk("hold_wd", avl_writedata, 32'hA1);
      if (i == 2) avl_waitrequest = 1'b0;
    end
    #1 chk("unwait_rdy", avl_ready, 1);
    nxt();
    chk("w2_addr", avl_address, 32'h102); chk("w2_wd", avl_writedata, 32'hA2); chk("w2_full", full, 0);
    wr_data = 32'hA3;
    nxt();
    chk("w3_addr", avl_address, 32'h103); chk("w3_wd", avl_writedata, 32'hA3); chk("w3_full", full, 1);
    wr_en = 1'b1;
    nxt();
    chk("wend_aw", avl_write, 0);
    chk("wlog_n", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("wlog_addr", log_addr[i], 32'h100 + i);
      chk("wlog_data", log_data[i], 32'hA0 + i);
    end

    // Read the frame back with 5-cycle read latency
    slave_en = 1'b1; rd_en = 1'b0;
    n_acc = 0; n_rdv = 0; n_data = 0; n_done = 0; prev_rdv = 1'b0;
    done_seen = 1'b0; finished = 1'b0;
    for (int t = 0; t < 80 && !finished; t++) begin
      if (t > 0) nxt();
      chk("rd_vld", rd_data_valid, prev_rdv);
      if (rd_data_valid) begin
        chk("rd_data", rd_data, 32'hA0 + n_data);
        n_data++;
      end
      if (done_seen) begin
        chk("post_done_full", full, 0);
        chk("post_done_pulse", rd_done, 0);
        finished = 1'b1;
      end else if (rd_done) begin
        n_done++;
        done_seen = 1'b1;
        chk("done_full", full, 1);
      end
      rd_en = (n_acc < 4) ? 1'b0 : 1'b1;
      #1;
      prev_rdv = avl_readdatavalid;
      if (avl_read_req) begin
        chk("rd_pend_lim", ((n_acc - n_rdv) < 2), 1);
        n_acc++;
      end
      if (avl_readdatavalid) begin
        if (n_rdv == 0) chk("rd_stall_3rd", n_acc, 2);
        n_rdv++;
      end
    end
    if (!finished) chk("rd_timeout", 0, 1);
    chk("rd_acc_n", n_acc, 4);
    chk("rd_data_n", n_data, 4);
    chk("rd_done_n", n_done, 1);

    // Simultaneous write and read request: only the write goes
    wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'hB0;
    #1 chk("both_req", avl_read_req, 0);
    nxt();
    chk("both_aw", avl_write, 1); chk("both_ar", avl_read, 0);
    chk("both_addr", avl_address, 32'h100); chk("both_wd", avl_writedata, 32'hB0);
    wr_en = 1'b1;

    // Reset with two reads outstanding
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      #1 if (avl_read_req) n++;
      if (n < 2) nxt();
    end
    chk("pre_rst_reads", n, 2);
    nxt();
    rd_en = 1'b1; reset = 1'b1;
    #1 chk("async_ar", avl_read, 0); chk("async_addr", avl_address, 0); chk("async_rd", rd_data, 0);
    nxt();
    reset = 1'b0; slave_en = 1'b0;
    chk_reset_vals("mid_rst");
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("stray_rdv", rd_data_valid, 0); chk("stray_rd", rd_data, 0);
      stray_rv = (i == 0 || i == 2);
    end
    nxt();
    stray_rv = 1'b0;
    chk("stray_rdv_end", rd_data_valid, 0); chk("stray_full", full, 0);
    // rd_pend must still be 0: exactly MAX_RD_PEND reads go out with no data back
    rd_en = 1'b0; n = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (avl_read_req) n++;
      nxt();
    end
    rd_en = 1'b1;
    chk("pend_no_underflow", n, 2);
    reset = 1'b1;
    nxt();
    reset = 1'b0;

`ifdef FB_OVERRUN_FLAG_EN
    // Overrun: a fifth write against a full frame
    nxt();
    chk("ovr_init", overrun, 0);
    n = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b0; wr_data = 32'hC0 + i;
      nxt();
    end
    chk("ovr_full", full, 1); chk("ovr_pre", overrun, 0);
    wr_data = 32'hC4;
    nxt();
    wr_en = 1'b1;
    chk("ovr_set", overrun, 1); chk("ovr_no_wr", avl_write, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("ovr_sticky", overrun, 1);
    end
    chk("ovr_wr_n", log_addr.size() - n, 4);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    chk("ovr_clear", overrun, 0);
`endif

    nxt();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
